// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter; grant/tx_send one cycle after an IDLE request with qualified ready.
// Holds requesters off until ready is stable for two cycles; optional watchdog via UART_TX_ARB_WATCHDOG_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 9,
  parameter int TIMEOUT_CYCLES = 32768
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         done,
  output logic                       tx_send,
  output logic [DATA_W-1:0]          tx_data,
  input  logic                       tx_ready,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       timeout
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_IDLE} state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic             tx_ready_d;
  logic             rdy_q;
  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] pick_next;
  logic             wd_hit;

  // A lone high cycle of tx_ready can precede the stop bit, so idle needs two.
  assign rdy_q = tx_ready && tx_ready_d;

  // First set request at or after the pointer; lowest offset wins.
  always_comb begin
    logic [IDX_W:0] cand;
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ))
        cand = cand - (IDX_W+1)'(NUM_REQ);
      if (req[cand[IDX_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[IDX_W-1:0];
      end
    end
  end

  assign pick_next = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;

`ifdef UART_TX_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            in_wait;

  assign in_wait = (state == WAIT_BUSY) || (state == WAIT_IDLE);
  assign wd_hit  = in_wait && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset || !in_wait || wd_hit || (state == WAIT_IDLE && rdy_q))
      wd_cnt <= '0;
    else
      wd_cnt <= wd_cnt + 1'b1;
  end
`else
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      tx_ready_d <= 1'b0;
      grant      <= '0;
      done       <= '0;
      tx_send    <= 1'b0;
      tx_data    <= '0;
      busy       <= 1'b0;
      owner      <= '0;
      timeout    <= 1'b0;
    end else begin
      tx_ready_d <= tx_ready;
      grant      <= '0;
      done       <= '0;
      tx_send    <= 1'b0;
      timeout    <= 1'b0;
      if (wd_hit) begin
        // Frame abandoned: release the owner so the bus cannot lock up.
        timeout <= 1'b1;
        done    <= NUM_REQ'(1) << owner;
        busy    <= 1'b0;
        state   <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (rdy_q && pick_vld) begin
              grant   <= NUM_REQ'(1) << pick_idx;
              tx_send <= 1'b1;
              tx_data <= req_data[pick_idx*DATA_W +: DATA_W];
              owner   <= pick_idx;
              busy    <= 1'b1;
              rr_ptr  <= pick_next;
              state   <= ISSUE;
            end
          end
          ISSUE: state <= WAIT_BUSY;
          WAIT_BUSY: begin
            if (!tx_ready)
              state <= WAIT_IDLE;
          end
          WAIT_IDLE: begin
            if (rdy_q) begin
              done  <= NUM_REQ'(1) << owner;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
